// File: rtl/scr1_tcm_dmem_port_if.sv
// SCR1 dmem request/response bundle between the core dmem router (master)
// and the TCM port-B initiator (slave).
interface scr1_tcm_dmem_port_if;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/scr1_tcm_dmem_port.sv
// Data-side initiator for TCM RAM port B: byte/half/word dmem accesses.
// Macro SCR1_TCM_BYTE_WR_EN: RAM honours byte enables; otherwise sub-word writes use read-modify-write.
module scr1_tcm_dmem_port #(
  parameter int          SCR1_WIDTH = 32,
  parameter logic [31:0] SCR1_SIZE  = 32'h00010000,
  localparam int         AW         = $clog2(SCR1_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scr1_tcm_dmem_port_if.slave   dmem,
  output logic                  mem_renb,
  output logic                  mem_wenb,
  output logic [3:0]            mem_webb,
  output logic [AW-3:0]         mem_addrb,
  output logic [SCR1_WIDTH-1:0] mem_datab,
  input  logic [SCR1_WIDTH-1:0] mem_qb
);

  localparam logic [1:0] RESP_IDLE = 2'b00;
  localparam logic [1:0] RESP_OKAY = 2'b01;
  localparam logic [1:0] RESP_ER   = 2'b10;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  resp_q, resp_d;
  logic [1:0]  off_q, off_d;
  logic        rd_q, rd_d;
`ifndef SCR1_TCM_BYTE_WR_EN
  logic [AW-3:0]         addr_q, addr_d;
  logic [3:0]            mask_q, mask_d;
  logic [SCR1_WIDTH-1:0] wdat_q, wdat_d;
  logic [SCR1_WIDTH-1:0] bit_mask;
`endif

  logic                  req_ack;
  logic                  accept;
  logic                  illegal;
  logic [3:0]            lane_mask;
  logic [SCR1_WIDTH-1:0] wdata_rep;
  logic [1:0]            off;
  logic                  unused_addr_hi;

  assign off            = dmem.dmem_addr[1:0];
  assign unused_addr_hi = ^dmem.dmem_addr[31:AW];

  // Gating with rst_n keeps the request interface quiet while reset is held.
  assign req_ack = rst_n && (state_q == IDLE);
  assign accept  = dmem.dmem_req && req_ack;

  always_comb begin
    illegal   = 1'b0;
    lane_mask = 4'b1111;
    wdata_rep = dmem.dmem_wdata;
    case (dmem.dmem_width)
      W_BYTE: begin
        lane_mask = 4'b0001 << off;
        wdata_rep = {4{dmem.dmem_wdata[7:0]}};
      end
      W_HALF: begin
        illegal   = off[0];
        lane_mask = 4'b0011 << off;
        wdata_rep = {2{dmem.dmem_wdata[15:0]}};
      end
      W_WORD:  illegal = (off != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

`ifndef SCR1_TCM_BYTE_WR_EN
  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < 4; i++) begin
      bit_mask[8*i +: 8] = {8{mask_q[i]}};
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    resp_d    = RESP_IDLE;
    off_d     = 2'b00;
    rd_d      = 1'b0;
`ifndef SCR1_TCM_BYTE_WR_EN
    addr_d    = addr_q;
    mask_d    = mask_q;
    wdat_d    = wdat_q;
`endif
    mem_renb  = 1'b0;
    mem_wenb  = 1'b0;
    mem_webb  = 4'b0000;
    mem_addrb = '0;
    mem_datab = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            resp_d = RESP_ER;
          end else if (!dmem.dmem_cmd) begin
            mem_renb  = 1'b1;
            mem_addrb = dmem.dmem_addr[AW-1:2];
            resp_d    = RESP_OKAY;
            rd_d      = 1'b1;
            off_d     = off;
          end else begin
`ifdef SCR1_TCM_BYTE_WR_EN
            mem_wenb  = 1'b1;
            mem_webb  = lane_mask;
            mem_addrb = dmem.dmem_addr[AW-1:2];
            mem_datab = wdata_rep;
            resp_d    = RESP_OKAY;
`else
            mem_addrb = dmem.dmem_addr[AW-1:2];
            if (dmem.dmem_width == W_WORD) begin
              mem_wenb  = 1'b1;
              mem_webb  = 4'b1111;
              mem_datab = wdata_rep;
              resp_d    = RESP_OKAY;
            end else begin
              // Fetch the old word now; it is merged with the new lanes next cycle.
              mem_renb = 1'b1;
              addr_d   = dmem.dmem_addr[AW-1:2];
              mask_d   = lane_mask;
              wdat_d   = wdata_rep;
              state_d  = RMW_WR;
            end
`endif
          end
        end
      end
`ifndef SCR1_TCM_BYTE_WR_EN
      RMW_WR: begin
        mem_wenb  = 1'b1;
        mem_webb  = 4'b1111;
        mem_addrb = addr_q;
        mem_datab = (mem_qb & ~bit_mask) | (wdat_q & bit_mask);
        resp_d    = RESP_OKAY;
        state_d   = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      resp_q  <= RESP_IDLE;
      off_q   <= 2'b00;
      rd_q    <= 1'b0;
`ifndef SCR1_TCM_BYTE_WR_EN
      addr_q  <= '0;
      mask_q  <= 4'b0000;
      wdat_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
`ifndef SCR1_TCM_BYTE_WR_EN
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdat_q  <= wdat_d;
`endif
    end
  end

  assign dmem.dmem_req_ack = req_ack;
  assign dmem.dmem_resp    = resp_q;
  assign dmem.dmem_rdata   = (resp_q == RESP_OKAY && rd_q) ? (mem_qb >> {off_q, 3'b000}) : '0;

endmodule

// File: tb/tb_scr1_tcm_dmem_port.sv
// Scoreboard bench for scr1_tcm_dmem_port: byte-array reference model, RAM model on port B,
// directed test-plan cases followed by randomized traffic.
module tb_scr1_tcm_dmem_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_renb, mem_wenb;
  logic [3:0]  mem_webb;
  logic [13:0] mem_addrb;
  logic [31:0] mem_datab;
  logic [31:0] mem_qb = 32'h0;

  always #5 clk = ~clk;

  scr1_tcm_dmem_port_if dif();

  scr1_tcm_dmem_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dmem      (dif),
    .mem_renb  (mem_renb),
    .mem_wenb  (mem_wenb),
    .mem_webb  (mem_webb),
    .mem_addrb (mem_addrb),
    .mem_datab (mem_datab),
    .mem_qb    (mem_qb)
  );

  // Port-B RAM: one-cycle read latency, byte enables honoured.
  logic [31:0] ram [0:16383];
  always @(posedge clk) begin
    if (mem_renb) mem_qb <= ram[mem_addrb];
    if (mem_wenb) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_webb[l]) ram[mem_addrb][8*l +: 8] <= mem_datab[8*l +: 8];
      end
    end
  end

  // Reference memory, byte addressed, covering the low 256 bytes that stimulus touches.
  logic [7:0] ref_mem [0:255];

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_word(logic [7:0] a);
    return {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}],
            ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
  endfunction

  // Monitor: every non-IDLE response pops one expectation.
  exp_t got_e;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dif.dmem_resp != 2'b00) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got resp=%b rdata=%h at cyc %0d, expected no response",
                   dif.dmem_resp, dif.dmem_rdata, cyc);
        end else begin
          got_e = sbq.pop_front();
          if (dif.dmem_resp !== got_e.resp || dif.dmem_rdata !== got_e.rdata || cyc != got_e.cyc) begin
            errors++;
            $display("FAIL resp_check: got resp=%b rdata=%h cyc=%0d, expected resp=%b rdata=%h cyc=%0d",
                     dif.dmem_resp, dif.dmem_rdata, cyc, got_e.resp, got_e.rdata, got_e.cyc);
          end else begin
            $display("resp ok: resp=%b rdata=%h cyc=%0d", dif.dmem_resp, dif.dmem_rdata, cyc);
          end
        end
      end else if (dif.dmem_rdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_rdata: got rdata=%h with resp IDLE, expected 00000000", dif.dmem_rdata);
      end
    end
  end

  // Called at negedge+1; returns at the next negedge+1 after acceptance.
  task automatic issue(input logic cmd, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] wd, output int waits);
    logic        illegal;
    logic [3:0]  mask;
    logic [19:0] exp_mem, got_mem;
    exp_t        e;
    int          lat;
    dif.dmem_req   = 1'b1;
    dif.dmem_cmd   = cmd;
    dif.dmem_width = w;
    dif.dmem_addr  = a;
    dif.dmem_wdata = wd;
    #1;
    waits = 0;
    while (!dif.dmem_req_ack && waits < 10) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!dif.dmem_req_ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got req_ack=0 for %0d cycles, expected 1", waits);
      dif.dmem_req = 1'b0;
      return;
    end
    illegal = (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'd0);
    mask = (w == 2'd0) ? (4'b0001 << a[1:0]) : (w == 2'd1) ? (4'b0011 << a[1:0]) : 4'b1111;
    lat = 1;
    if (illegal)      exp_mem = 20'h0;
    else if (!cmd)    exp_mem = {1'b1, 1'b0, 4'h0, a[15:2]};
    else begin
`ifdef SCR1_TCM_BYTE_WR_EN
      exp_mem = {1'b0, 1'b1, mask, a[15:2]};
`else
      if (w == 2'd2) exp_mem = {1'b0, 1'b1, 4'hF, a[15:2]};
      else begin
        exp_mem = {1'b1, 1'b0, 4'h0, a[15:2]};
        lat = 2;
      end
`endif
    end
    got_mem = {mem_renb, mem_wenb, (mem_wenb ? mem_webb : 4'h0),
               ((mem_renb | mem_wenb) ? mem_addrb : 14'h0)};
    checks++;
    if (got_mem !== exp_mem) begin
      errors++;
      $display("FAIL accept_mem: got {renb,wenb,webb,addrb}=%h, expected %h (cmd=%b w=%b a=%h)",
               got_mem, exp_mem, cmd, w, a);
    end
    e.cyc   = cyc + lat;
    e.resp  = illegal ? 2'b10 : 2'b01;
    e.rdata = (!illegal && !cmd) ? (ref_word(a[7:0]) >> (8 * a[1:0])) : 32'h0;
    if (!illegal && cmd) begin
      for (int b = 0; b < (1 << w); b++) ref_mem[a[7:0] + 8'(b)] = wd[8*b +: 8];
    end
    sbq.push_back(e);
    $display("req: cmd=%b width=%b addr=%h wdata=%h -> expect resp=%b rdata=%h",
             cmd, w, a, wd, e.resp, e.rdata);
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    dif.dmem_req = 1'b0;
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  int          wt;
  logic [1:0]  rw;
  logic [31:0] ra;
  int          sel;

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = init_word(i);
    for (int b = 0; b < 256; b++) ref_mem[b] = init_word(b / 4) >> (8 * (b % 4));
    dif.dmem_req   = 1'b1;
    dif.dmem_cmd   = 1'b1;
    dif.dmem_width = 2'd2;
    dif.dmem_addr  = 32'h10;
    dif.dmem_wdata = 32'hFFFFFFFF;

    // Reset state with a request pending: everything must stay quiet.
    #12;
    checks++;
    if ({dif.dmem_req_ack, dif.dmem_resp, mem_renb, mem_wenb, mem_webb} !== 9'h0 ||
        mem_addrb !== 14'h0 || mem_datab !== 32'h0 || dif.dmem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got ack=%b resp=%b renb=%b wenb=%b webb=%b addrb=%h datab=%h, expected all 0",
               dif.dmem_req_ack, dif.dmem_resp, mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab);
    end
    dif.dmem_req = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Word write / read, lane-shifted reads.
    issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, wt);
    issue(1'b0, 2'd2, 32'h10, 32'h0, wt);
    issue(1'b0, 2'd0, 32'h13, 32'h0, wt);
    issue(1'b0, 2'd1, 32'h12, 32'h0, wt);
    idle(1);
    // Half write merged over an existing word.
    issue(1'b1, 2'd2, 32'h10, 32'h11223344, wt);
    issue(1'b1, 2'd1, 32'h12, 32'h0000A5A5, wt);
    issue(1'b0, 2'd2, 32'h10, 32'h0, wt);
    idle(1);
    // Illegal requests.
    issue(1'b0, 2'd2, 32'h02, 32'h0, wt);
    issue(1'b0, 2'd1, 32'h01, 32'h0, wt);
    issue(1'b0, 2'd3, 32'h00, 32'h0, wt);
    issue(1'b1, 2'd3, 32'h04, 32'h12345678, wt);
    idle(2);
    // Streaming word reads with the request held high.
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 2'd2, 32'(4 * i), 32'h0, wt);
      checks++;
      if (wt != 0) begin
        errors++;
        $display("FAIL stream_ack: got %0d wait cycles on read %0d, expected 0", wt, i);
      end
    end
    idle(2);

`ifndef SCR1_TCM_BYTE_WR_EN
    // Reset in the middle of a read-modify-write abandons the write.
    dif.dmem_req   = 1'b1;
    dif.dmem_cmd   = 1'b1;
    dif.dmem_width = 2'd1;
    dif.dmem_addr  = 32'h22;
    dif.dmem_wdata = 32'h0000BEEF;
    #1;
    checks++;
    if (dif.dmem_req_ack !== 1'b1) begin
      errors++;
      $display("FAIL rmw_accept: got req_ack=%b, expected 1", dif.dmem_req_ack);
    end
    @(posedge clk); #1;
    dif.dmem_req = 1'b0;
    checks++;
    if (dif.dmem_req_ack !== 1'b0 || mem_wenb !== 1'b1) begin
      errors++;
      $display("FAIL rmw_phase: got req_ack=%b wenb=%b, expected 0 and 1", dif.dmem_req_ack, mem_wenb);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dif.dmem_resp, mem_wenb, mem_renb, dif.dmem_req_ack} !== 5'h0) begin
      errors++;
      $display("FAIL rmw_reset: got resp=%b wenb=%b renb=%b ack=%b, expected all 0",
               dif.dmem_resp, mem_wenb, mem_renb, dif.dmem_req_ack);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (dif.dmem_req_ack !== 1'b1) begin
      errors++;
      $display("FAIL rmw_release_ack: got req_ack=%b, expected 1", dif.dmem_req_ack);
    end
    idle(1);
    issue(1'b0, 2'd2, 32'h20, 32'h0, wt);
    idle(1);
`else
    rst_n = 1'b0;
    #1;
    checks++;
    if (dif.dmem_req_ack !== 1'b0 || dif.dmem_resp !== 2'b00) begin
      errors++;
      $display("FAIL reset_pulse: got ack=%b resp=%b, expected 0 and 00", dif.dmem_req_ack, dif.dmem_resp);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (dif.dmem_req_ack !== 1'b1) begin
      errors++;
      $display("FAIL release_ack: got req_ack=%b, expected 1", dif.dmem_req_ack);
    end
    idle(1);
`endif

    // Randomized traffic over the low 256 bytes.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      rw  = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      ra  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (rw == 2'd1) ra[0] = 1'b0;
        if (rw == 2'd2) ra[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), rw, ra, $urandom, wt);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL missing_resp: got %0d outstanding expectations, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scr1_tcm_dmem_port.md
Name: scr1_tcm_dmem_port

Overview:
- Data-side initiator for port B of the TCM dual-port RAM.
- Accepts SCR1 dmem requests (byte/half/word, read/write) and generates renb/wenb/webb/addrb/datab.
- Returns lane-aligned read data and a response one cycle after the RAM access.
- Sits between the core dmem router and the TCM RAM; port A remains on the imem path.

Parameters:
SCR1_WIDTH, 32, data width in bits; only 32 is supported.
SCR1_SIZE, 32'h00010000, TCM size in bytes; AW = $clog2(SCR1_SIZE).

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
dmem_req  in  1  request valid
dmem_cmd  in  1  0 = read, 1 = write
dmem_width  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
dmem_addr  in  32  byte address; bits [AW-1:0] are used
dmem_wdata  in  32  write data, LSB-justified
dmem_req_ack  out  1  request accepted this cycle
dmem_rdata  out  32  read data, shifted to the LSB
dmem_resp  out  2  00 = IDLE, 01 = OKAY, 10 = ER
mem_renb  out  1  RAM port B read enable
mem_wenb  out  1  RAM port B write enable
mem_webb  out  4  RAM port B byte enables
mem_addrb  out  AW-2  RAM word address, equal to dmem_addr[AW-1:2]
mem_datab  out  32  RAM write data
mem_qb  in  32  RAM read data, valid 1 cycle after mem_renb

Behaviour:
- FSM states: IDLE and RMW_WR. RMW_WR is reachable only when SCR1_TCM_BYTE_WR_EN is undefined.
- Reset (async, rst_n = 0):
  - state = IDLE; dmem_resp = IDLE; registered offset/read flag = 0.
  - Reset forces dmem_req_ack = 0 and all mem_* outputs = 0.
- dmem_req_ack = 1 iff state == IDLE. accept = dmem_req & dmem_req_ack.
- mem_* outputs are combinational and all 0 unless accept is high, or state == RMW_WR.
- Illegal request:
  - Condition: width 11, half with addr[0] = 1, or word with addr[1:0] != 0.
  - Action: no mem enable; dmem_resp = ER in the next cycle.
- Read accept:
  - mem_renb = 1, mem_addrb = addr[AW-1:2]; offset addr[1:0] is registered.
  - Next cycle: dmem_resp = OKAY, dmem_rdata = mem_qb >> (8*offset), vacated bits 0.
  - Sign/zero extension is not performed here.
- Write lane mask:
  - byte: 4'b0001 << off; half: 4'b0011 << off; word: 4'b1111.
- Write data replication:
  - mem_datab = byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Write accept (word, or any width with the macro defined):
  - mem_wenb = 1, mem_webb = mask; dmem_resp = OKAY in the next cycle.
- dmem_resp pulses for exactly 1 cycle per accepted request and is IDLE otherwise.
- dmem_rdata = 0 whenever the current response is not an OKAY read.
- Back-to-back: in IDLE a new request may be accepted in the same cycle that the previous response is presented. Single-cycle ops therefore sustain 1 request/cycle.
- dmem_req with dmem_req_ack = 0 is ignored; the requester must hold the request.

Optional Feature:
SCR1_TCM_BYTE_WR_EN
- Defined: the RAM honours mem_webb; every write is single-cycle as above; RMW_WR is unused.
- Undefined: the RAM writes whole words only, so mem_webb is always 4'b1111 when mem_wenb = 1. Sub-word writes use read-modify-write:
  - Cycle 0 (accept): mem_renb = 1; latch word address, mask and replicated data; go to RMW_WR.
  - Cycle 1 (RMW_WR): dmem_req_ack = 0, mem_wenb = 1, mem_webb = 4'b1111, mem_addrb = latched address.
  - Cycle 1 write data: mem_datab = (mem_qb & ~M) | (data & M), where M expands the mask to bits. Go to IDLE.
  - Cycle 2: dmem_resp = OKAY; a new request may be accepted.
  - Reset asserted during RMW_WR abandons the write; no mem_wenb after release.

Test Plan:
- Word write addr 0x10, data 0xDEADBEEF, then word read 0x10 -> mem_wenb at 0x4 with webb 1111; read resp OKAY 1 cycle after accept; rdata 0xDEADBEEF.
- Byte read addr 0x13 with word 0xDEADBEEF -> rdata 0x000000DE; half read addr 0x12 -> rdata 0x0000DEAD.
- Half write 0xA5A5 at addr 0x12 over 0x11223344:
  - Macro defined: webb 1100, single cycle.
  - Macro undefined: req_ack low for 1 cycle, written word 0xA5A53344, resp at cycle 2.
  - Both: subsequent word read returns 0xA5A53344.
- Word read at 0x2, half at 0x1, width 11 -> no mem_renb/wenb; resp ER for 1 cycle each.
- Streaming 4 word reads at 0x0, 0x4, 0x8, 0xC with req held high -> req_ack high every cycle; 4 consecutive OKAY responses with correct data.
- rst_n low during RMW_WR (macro undefined) -> resp IDLE, mem_wenb 0, target word unchanged, req_ack 1 after release.
